// File: rtl/bram_accum_ctrl.sv
// Sequencer for a single-port block RAM: loads a burst of bytes, reads them back
// with read-latency compensation and accumulates them into a wide sum with sticky overflow.
module bram_accum_ctrl #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1,
    parameter int ACC_W  = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    input  logic              abort,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              busy,
    output logic              done,
    output logic [ACC_W-1:0]  sum,
    output logic              sum_ovf
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int              DEPTH   = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] MAX_LEN = DEPTH[ADDR_W:0];

    state_t              state_r;
    logic [ADDR_W:0]     len_r;
    logic [ADDR_W-1:0]   wptr_r;
    logic [ADDR_W-1:0]   rptr_r;
    logic [RD_LAT-1:0]   tag_r;
    logic [ACC_W-1:0]    sum_r;
    logic                sum_ovf_r;
    logic                done_r;
    logic                busy_r;
    logic                wr_ready_r;

    logic [ADDR_W:0]     len_sat_s;
    logic [ADDR_W:0]     last_idx_s;
    logic                wr_fire_s;
    logic                wr_last_s;
    logic                rd_last_s;
    logic                abort_hit_s;
    logic                tag_pending_s;
    logic [ACC_W:0]      acc_s;

    // Control decode: length saturation, last-word detection, tag occupancy and adder.
    always_comb begin
        len_sat_s     = (len > MAX_LEN) ? MAX_LEN : len;
        last_idx_s    = len_r - 1'b1;
        wr_fire_s     = wr_valid & wr_ready_r;
        wr_last_s     = ({1'b0, wptr_r} == last_idx_s);
        rd_last_s     = ({1'b0, rptr_r} == last_idx_s);
        abort_hit_s   = abort && (state_r inside {ST_LOAD, ST_READ, ST_DRAIN});
        acc_s         = {1'b0, sum_r} + {{(ACC_W + 1 - DATA_W){1'b0}}, mem_dout};
        // Tags below the last stage are reads whose data has not yet arrived.
        tag_pending_s = 1'b0;
        for (int i = 0; i < RD_LAT - 1; i++) begin
            tag_pending_s = tag_pending_s | tag_r[i];
        end
    end

    // RAM port drive: writes follow the stream directly in LOAD, reads walk rptr in READ.
    always_comb begin
        mem_en   = 1'b0;
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_din  = '0;
        case (state_r)
            ST_LOAD: begin
                mem_en   = wr_valid;
                mem_we   = wr_valid;
                mem_addr = wptr_r;
                mem_din  = wr_data;
            end
            ST_READ: begin
                mem_en   = 1'b1;
                mem_addr = rptr_r;
            end
            default: begin
                mem_en   = 1'b0;
            end
        endcase
    end

    // Read-tag pipeline matching the RAM read latency; flushed on abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_r <= '0;
        end else if (abort_hit_s) begin
            tag_r <= '0;
        end else begin
            tag_r[0] <= (state_r == ST_READ);
            for (int i = 1; i < RD_LAT; i++) begin
                tag_r[i] <= tag_r[i-1];
            end
        end
    end

    // Main sequencer with accumulator and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            len_r      <= '0;
            wptr_r     <= '0;
            rptr_r     <= '0;
            sum_r      <= '0;
            sum_ovf_r  <= 1'b0;
            done_r     <= 1'b0;
            busy_r     <= 1'b0;
            wr_ready_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (tag_r[RD_LAT-1]) begin
                sum_r <= acc_s[ACC_W-1:0];
                if (acc_s[ACC_W]) begin
                    sum_ovf_r <= 1'b1;
                end
            end
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        len_r     <= len_sat_s;
                        sum_r     <= '0;
                        sum_ovf_r <= 1'b0;
                        wptr_r    <= '0;
                        busy_r    <= 1'b1;
                        if (len_sat_s == '0) begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                        end else begin
                            state_r    <= ST_LOAD;
                            wr_ready_r <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (abort) begin
                        state_r    <= ST_IDLE;
                        busy_r     <= 1'b0;
                        wr_ready_r <= 1'b0;
                    end else if (wr_fire_s) begin
                        wptr_r <= wptr_r + 1'b1;
                        if (wr_last_s) begin
                            state_r    <= ST_READ;
                            rptr_r     <= '0;
                            wr_ready_r <= 1'b0;
                        end
                    end
                end
                ST_READ: begin
                    if (abort) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        rptr_r <= rptr_r + 1'b1;
                        if (rd_last_s) begin
                            state_r <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (abort) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else if (!tag_pending_s) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    busy_r     <= 1'b0;
                    wr_ready_r <= 1'b0;
                end
            endcase
        end
    end

    assign wr_ready = wr_ready_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign sum      = sum_r;
    assign sum_ovf  = sum_ovf_r;

endmodule
